// File: rtl/recorre_ram_multicanal.sv
// Multi-channel RAM address walker: each channel steps through its own window on every
// sample tick, and the block issues one read per active channel in ascending index order.
module recorre_ram_multicanal #(
  parameter int ADDR_W      = 26,
  parameter int NUM_CANALES = 2,
  parameter int CANAL_W     = 1,
  parameter int PASO_BASE   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic [1:0]                    nivel,
  input  logic [NUM_CANALES-1:0]        disparo,
  input  logic [NUM_CANALES-1:0]        modo_loop,
  input  logic                          detener,
  input  logic [NUM_CANALES*ADDR_W-1:0] dir_inicio,
  input  logic [NUM_CANALES*ADDR_W-1:0] dir_fin,
  output logic [ADDR_W-1:0]             dir_ram,
  output logic [CANAL_W-1:0]            canal_ram,
  output logic                          dir_valida,
  input  logic                          ram_listo,
  output logic [NUM_CANALES-1:0]        activo,
  output logic [NUM_CANALES-1:0]        fin_canal,
  output logic                          sobrecarga,
  output logic [1:0]                    estado_dbg
);

  typedef enum logic [1:0] {REPOSO = 2'd0, ACTUALIZA = 2'd1, EMITE = 2'd2} estado_t;

  estado_t                estado_q, estado_d;
  logic [ADDR_W-1:0]      dir_q [NUM_CANALES];
  logic [ADDR_W-1:0]      dir_d [NUM_CANALES];
  logic [NUM_CANALES-1:0] activo_q, activo_d;
  logic [NUM_CANALES-1:0] pend_q, pend_d;
  logic [NUM_CANALES-1:0] fin_canal_q, fin_canal_d;
  logic [ADDR_W-1:0]      dir_ram_q, dir_ram_d;
  logic [CANAL_W-1:0]     canal_ram_q, canal_ram_d;
  logic                   dir_valida_q, dir_valida_d;
  logic                   sobrecarga_q, sobrecarga_d;

  logic [ADDR_W:0]        paso;
  logic [ADDR_W:0]        suma;
  logic [NUM_CANALES-1:0] busca;
  logic [NUM_CANALES-1:0] resto;
  logic [CANAL_W-1:0]     sel_idx;

  function automatic logic [CANAL_W-1:0] menor_idx(input logic [NUM_CANALES-1:0] m);
    logic [CANAL_W-1:0] r;
    r = '0;
    for (int i = NUM_CANALES - 1; i >= 0; i--) begin
      if (m[i]) r = CANAL_W'(i);
    end
    return r;
  endfunction

  // Request handshake: dir_ram/canal_ram are held stable while dir_valida=1 and the
  // transfer happens on the rising edge where dir_valida & ram_listo are both high.
  always_comb begin
    estado_d     = estado_q;
    dir_d        = dir_q;
    activo_d     = activo_q;
    pend_d       = pend_q;
    fin_canal_d  = '0;
    dir_ram_d    = dir_ram_q;
    canal_ram_d  = canal_ram_q;
    dir_valida_d = dir_valida_q;
    sobrecarga_d = 1'b0;
    paso         = (ADDR_W+1)'(PASO_BASE) + {{(ADDR_W-1){1'b0}}, nivel};
    suma         = '0;
    busca        = '0;
    resto        = pend_q;
    sel_idx      = '0;

    if (detener) begin
      activo_d     = '0;
      pend_d       = '0;
      dir_valida_d = 1'b0;
      estado_d     = REPOSO;
    end else begin
      for (int i = 0; i < NUM_CANALES; i++) begin
        if (disparo[i] && !activo_q[i]) begin
          dir_d[i]    = dir_inicio[i*ADDR_W +: ADDR_W];
          activo_d[i] = 1'b1;
        end
      end
      if (tick && estado_q != REPOSO) sobrecarga_d = 1'b1;

      case (estado_q)
        REPOSO: begin
          if (tick) begin
            for (int i = 0; i < NUM_CANALES; i++) begin
              if (activo_q[i]) begin
                suma = {1'b0, dir_q[i]} + paso;
                if (suma <= {1'b0, dir_fin[i*ADDR_W +: ADDR_W]}) begin
                  dir_d[i] = suma[ADDR_W-1:0];
                end else if (modo_loop[i]) begin
                  dir_d[i] = dir_inicio[i*ADDR_W +: ADDR_W];
                end else begin
                  activo_d[i]    = 1'b0;
                  fin_canal_d[i] = 1'b1;
                end
              end
            end
            // Channels loaded this very cycle are not in the snapshot: they wait for the next tick.
            pend_d   = activo_q & ~fin_canal_d;
            estado_d = ACTUALIZA;
          end
        end
        ACTUALIZA: begin
          if (pend_q == '0) begin
            estado_d = REPOSO;
          end else begin
            busca        = pend_q;
            dir_valida_d = 1'b1;
            estado_d     = EMITE;
          end
        end
        EMITE: begin
          if (ram_listo) begin
            resto[canal_ram_q] = 1'b0;
            pend_d             = resto;
            if (resto == '0) begin
              dir_valida_d = 1'b0;
              estado_d     = REPOSO;
            end else begin
              busca = resto;
            end
          end
        end
        default: estado_d = REPOSO;
      endcase

      if (busca != '0) begin
        sel_idx     = menor_idx(busca);
        dir_ram_d   = dir_q[sel_idx];
        canal_ram_d = sel_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q     <= REPOSO;
      for (int i = 0; i < NUM_CANALES; i++) dir_q[i] <= '0;
      activo_q     <= '0;
      pend_q       <= '0;
      fin_canal_q  <= '0;
      dir_ram_q    <= '0;
      canal_ram_q  <= '0;
      dir_valida_q <= 1'b0;
      sobrecarga_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      for (int i = 0; i < NUM_CANALES; i++) dir_q[i] <= dir_d[i];
      activo_q     <= activo_d;
      pend_q       <= pend_d;
      fin_canal_q  <= fin_canal_d;
      dir_ram_q    <= dir_ram_d;
      canal_ram_q  <= canal_ram_d;
      dir_valida_q <= dir_valida_d;
      sobrecarga_q <= sobrecarga_d;
    end
  end

  assign dir_ram    = dir_ram_q;
  assign canal_ram  = canal_ram_q;
  assign dir_valida = dir_valida_q;
  assign activo     = activo_q;
  assign fin_canal  = fin_canal_q;
  assign sobrecarga = sobrecarga_q;
  assign estado_dbg = estado_q;

endmodule

// File: tb/tb_recorre_ram_multicanal.sv
// Bench for recorre_ram_multicanal: table-driven single-channel walks, then hand-written
// multi-cycle sequences; every accepted read is checked against an expected queue.
module tb_recorre_ram_multicanal;

  localparam int ADDR_W = 26;
  localparam int NC     = 2;
  localparam int CW     = 1;
  localparam int W      = CW + ADDR_W;

  logic              clk;
  logic              reset;
  logic              tick;
  logic [1:0]        nivel;
  logic [NC-1:0]     disparo;
  logic [NC-1:0]     modo_loop;
  logic              detener;
  logic [NC*ADDR_W-1:0] dir_inicio;
  logic [NC*ADDR_W-1:0] dir_fin;
  logic [ADDR_W-1:0] dir_ram;
  logic [CW-1:0]     canal_ram;
  logic              dir_valida;
  logic              ram_listo;
  logic [NC-1:0]     activo;
  logic [NC-1:0]     fin_canal;
  logic              sobrecarga;
  logic [1:0]        estado_dbg;

  int n_chk;
  int n_fail;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        dispara;
    logic        modo;
    logic [1:0]  niv;
    logic        emite;
    logic [25:0] dir;
    logic [1:0]  fin;
    logic [1:0]  act;
  } fila_t;

  fila_t tabla[15];

  recorre_ram_multicanal #(
    .ADDR_W(ADDR_W), .NUM_CANALES(NC), .CANAL_W(CW), .PASO_BASE(2)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .nivel(nivel), .disparo(disparo),
    .modo_loop(modo_loop), .detener(detener), .dir_inicio(dir_inicio), .dir_fin(dir_fin),
    .dir_ram(dir_ram), .canal_ram(canal_ram), .dir_valida(dir_valida), .ram_listo(ram_listo),
    .activo(activo), .fin_canal(fin_canal), .sobrecarga(sobrecarga), .estado_dbg(estado_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    nxt();
    tick = 1'b0;
  endtask

  task automatic wait_reposo();
    int k;
    k = 0;
    while (estado_dbg != 2'd0 && k < 40) begin
      nxt();
      k++;
    end
    chk("scan_done", 64'(estado_dbg), 64'd0);
  endtask

  task automatic parar();
    detener = 1'b1;
    nxt();
    detener = 1'b0;
  endtask

  // scoreboard: compare every accepted request with the head of the expected queue
  always @(negedge clk) begin
    if (!reset && dir_valida && ram_listo) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got canal=%0d dir=%h, expected no request", canal_ram, dir_ram);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_request", 64'({canal_ram, dir_ram}), 64'(e));
      end
    end
  end

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; tick = 1'b0; nivel = 2'd0; disparo = '0; modo_loop = '0;
    detener = 1'b0; ram_listo = 1'b0;
    dir_inicio = {26'h0, 26'h100};
    dir_fin    = {26'h3FFFFFF, 26'h10F};

    for (int r = 0; r < 15; r++) begin
      tabla[r] = '{1'b0, 1'b0, 2'd0, 1'b0, 26'h0, 2'b00, 2'b00};
    end
    for (int r = 0; r < 7; r++) begin
      tabla[r] = '{(r == 0), 1'b0, 2'd0, 1'b1, 26'(32'h102 + 2 * r), 2'b00, 2'b01};
    end
    tabla[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 26'h0,   2'b01, 2'b00};
    tabla[10] = '{1'b1, 1'b1, 2'd3, 1'b1, 26'h105, 2'b00, 2'b01};
    tabla[11] = '{1'b0, 1'b1, 2'd3, 1'b1, 26'h10A, 2'b00, 2'b01};
    tabla[12] = '{1'b0, 1'b1, 2'd3, 1'b1, 26'h10F, 2'b00, 2'b01};
    tabla[13] = '{1'b0, 1'b1, 2'd3, 1'b1, 26'h100, 2'b00, 2'b01};
    tabla[14] = '{1'b0, 1'b1, 2'd3, 1'b1, 26'h105, 2'b00, 2'b01};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", 64'(dir_valida), 64'd0);
    chk("rst_dir", 64'(dir_ram), 64'd0);
    chk("rst_activo", 64'(activo), 64'd0);
    chk("rst_estado", 64'(estado_dbg), 64'd0);
    reset = 1'b0;
    nxt();

    // asynchronous reset in the middle of a pending request
    disparo = 2'b01; nxt(); disparo = '0;
    do_tick();
    nxt();
    chk("pre_rst_valid", 64'(dir_valida), 64'd1);
    chk("pre_rst_dir", 64'(dir_ram), 64'h102);
    reset = 1'b1;
    #1;
    chk("async_valid", 64'(dir_valida), 64'd0);
    chk("async_dir", 64'(dir_ram), 64'd0);
    chk("async_activo", 64'(activo), 64'd0);
    nxt();
    reset = 1'b0;
    nxt();
    chk("post_rst_estado", 64'(estado_dbg), 64'd0);
    chk("post_rst_valid", 64'(dir_valida), 64'd0);

    // table: one-shot walk (paso 2) then looping walk (paso 5) on channel 0
    ram_listo = 1'b1;
    for (int r = 0; r < 15; r++) begin
      modo_loop = {1'b0, tabla[r].modo};
      nivel     = tabla[r].niv;
      if (tabla[r].dispara) begin
        disparo = 2'b01; nxt(); disparo = '0;
      end
      if (tabla[r].emite) exp_q.push_back({1'b0, tabla[r].dir});
      do_tick();
      chk("tab_fin_canal", 64'(fin_canal), 64'(tabla[r].fin));
      chk("tab_activo", 64'(activo), 64'(tabla[r].act));
      wait_reposo();
    end
    chk("tab_queue_empty", 64'(exp_q.size()), 64'd0);
    parar();
    chk("stop_activo", 64'(activo), 64'd0);

    // two channels, stalled controller, dropped tick
    modo_loop = '0; nivel = 2'd0;
    dir_inicio = {26'h285FF0, 26'h0};
    dir_fin    = {26'h3FFFFFF, 26'hFFFF};
    disparo = 2'b11; nxt(); disparo = '0;
    chk("both_activo", 64'(activo), 64'h3);
    ram_listo = 1'b0;
    exp_q.push_back({1'b0, 26'h2});
    exp_q.push_back({1'b1, 26'h285FF2});
    do_tick();
    chk("lat_t1_valid", 64'(dir_valida), 64'd0);
    nxt();
    for (int c = 0; c < 4; c++) begin
      chk("hold_valid", 64'(dir_valida), 64'd1);
      chk("hold_canal", 64'(canal_ram), 64'd0);
      chk("hold_dir", 64'(dir_ram), 64'h2);
      if (c == 1) chk("sobrecarga_on", 64'(sobrecarga), 64'd1);
      if (c == 2) chk("sobrecarga_off", 64'(sobrecarga), 64'd0);
      tick = (c == 0);
      if (c == 3) ram_listo = 1'b1;
      nxt();
    end
    chk("ch1_valid", 64'(dir_valida), 64'd1);
    chk("ch1_canal", 64'(canal_ram), 64'd1);
    chk("ch1_dir", 64'(dir_ram), 64'h285FF2);
    wait_reposo();
    exp_q.push_back({1'b0, 26'h4});
    exp_q.push_back({1'b1, 26'h285FF4});
    do_tick();
    wait_reposo();

    // detener while channel 1 request is pending
    ram_listo = 1'b0;
    exp_q.push_back({1'b0, 26'h6});
    do_tick();
    nxt();
    chk("det_ch0_dir", 64'(dir_ram), 64'h6);
    ram_listo = 1'b1;
    nxt();
    ram_listo = 1'b0;
    chk("det_ch1_valid", 64'(dir_valida), 64'd1);
    chk("det_ch1_dir", 64'(dir_ram), 64'h285FF6);
    parar();
    chk("det_valid", 64'(dir_valida), 64'd0);
    chk("det_activo", 64'(activo), 64'd0);
    chk("det_estado", 64'(estado_dbg), 64'd0);
    disparo = 2'b10; nxt(); disparo = '0;
    chk("restart_activo", 64'(activo), 64'h2);
    ram_listo = 1'b1;
    exp_q.push_back({1'b1, 26'h285FF2});
    do_tick();
    wait_reposo();

    // trigger of channel 1 during channel 0 scan
    parar();
    disparo = 2'b01; nxt(); disparo = '0;
    ram_listo = 1'b0;
    exp_q.push_back({1'b0, 26'h2});
    do_tick();
    nxt();
    disparo = 2'b10; nxt(); disparo = '0;
    chk("mid_activo", 64'(activo), 64'h3);
    chk("mid_canal", 64'(canal_ram), 64'd0);
    ram_listo = 1'b1;
    nxt();
    chk("mid_no_ch1", 64'(dir_valida), 64'd0);
    exp_q.push_back({1'b0, 26'h4});
    exp_q.push_back({1'b1, 26'h285FF2});
    do_tick();
    wait_reposo();

    // disparo and tick in the same cycle: load wins, no advance
    parar();
    disparo = 2'b01; tick = 1'b1; nxt(); disparo = '0; tick = 1'b0;
    chk("same_activo", 64'(activo), 64'h1);
    wait_reposo();
    exp_q.push_back({1'b0, 26'h2});
    do_tick();
    wait_reposo();

    // inverted window on channel 1: one-shot ends, loop reloads
    parar();
    dir_inicio[ADDR_W +: ADDR_W] = 26'h50;
    dir_fin[ADDR_W +: ADDR_W]    = 26'h40;
    disparo = 2'b10; nxt(); disparo = '0;
    do_tick();
    chk("inv_fin_canal", 64'(fin_canal), 64'h2);
    chk("inv_activo", 64'(activo), 64'h0);
    wait_reposo();
    modo_loop = 2'b10;
    disparo = 2'b10; nxt(); disparo = '0;
    exp_q.push_back({1'b1, 26'h50});
    do_tick();
    chk("inv_loop_activo", 64'(activo), 64'h2);
    wait_reposo();

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/recorre_ram_multicanal.md
Name: recorre_ram_multicanal

Overview:
Parametrised, multi-channel successor to the single-song RAM address walker. Each of NUM_CANALES channels walks its own address window from dir_inicio to dir_fin. The step per sample tick is PASO_BASE plus the difficulty level. One-shot or looping mode is selectable per channel. Per tick, the block issues one read per active channel to the shared SDRAM/RAM controller over a valid/ready handshake, scanning channels in ascending index order.

Parameters:
ADDR_W, 26, width of each RAM address.
NUM_CANALES, 2, number of independent address channels.
CANAL_W, 1, width of channel index; must equal ceil(log2(NUM_CANALES)), minimum 1.
PASO_BASE, 2, base address increment per tick.

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset  in  1  asynchronous, active-high reset.
tick  in  1  one-cycle sample strobe.
nivel  in  2  difficulty level 0..3, added to the step.
disparo  in  NUM_CANALES  per-channel start trigger; level-sampled each cycle.
modo_loop  in  NUM_CANALES  1 = channel reloads dir_inicio at end of window, 0 = channel stops.
detener  in  1  synchronous stop of all channels.
dir_inicio  in  NUM_CANALES*ADDR_W  packed start addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
dir_fin  in  NUM_CANALES*ADDR_W  packed inclusive end addresses, same packing.
dir_ram  out  ADDR_W  address of the current read request.
canal_ram  out  CANAL_W  channel owning dir_ram.
dir_valida  out  1  read request valid.
ram_listo  in  1  controller accepts the request when dir_valida & ram_listo.
activo  out  NUM_CANALES  per-channel active flag.
fin_canal  out  NUM_CANALES  one-cycle pulse when a one-shot channel finishes.
sobrecarga  out  1  one-cycle pulse when a tick is dropped.

Behaviour:
- Reset values: every output 0, all channel addresses 0, FSM in REPOSO. Reset may assert at any time, including mid-scan; it clears everything immediately.
- Channel state is INACTIVO or ACTIVO.
  - disparo[i]=1 while channel i is INACTIVO: next cycle dir[i] <= dir_inicio[i] and activo[i] <= 1.
  - disparo[i] while channel i is ACTIVO is ignored; no retrigger.
- detener=1: next cycle all channels go INACTIVO, dir_valida <= 0, FSM goes to REPOSO. This aborts a pending request, and it overrides disparo and tick in the same cycle.
- Step: paso = PASO_BASE + nivel, with nivel sampled at the tick cycle. Sums are computed in ADDR_W+1 bits, so there is no wrap.
- tick accepted (FSM in REPOSO, detener=0): in the next cycle, for every ACTIVO channel:
  - sum = dir[i] + paso.
  - If sum <= dir_fin[i]: dir[i] <= sum.
  - Otherwise, if modo_loop[i]=1: dir[i] <= dir_inicio[i].
  - Otherwise: activo[i] <= 0 and fin_canal[i] pulses for one cycle. No request is issued for that channel this tick.
- The active mask is snapshotted at the same edge, after the update; it is called pendientes.
- If dir_inicio > dir_fin, the channel still activates, and the first tick ends it (one-shot) or reloads it (loop).
- Issue FSM:
  - REPOSO: on accepted tick go to ACTUALIZA.
  - ACTUALIZA (1 cycle, addresses updated): if pendientes==0 go to REPOSO, else go to EMITE presenting the lowest set index.
  - EMITE: dir_valida=1; dir_ram and canal_ram are held stable until the handshake completes. On dir_valida & ram_listo, clear that bit in pendientes and present the next lowest set index in the following cycle; after the last one, dir_valida <= 0 and go to REPOSO.
  - Back-to-back: with ram_listo held at 1, one request is issued per cycle.
- Latency: tick at cycle t gives the first dir_valida at cycle t+2.
- tick while FSM is not in REPOSO: the tick is dropped, sobrecarga pulses at t+1, and addresses and pendientes are unchanged.
- A channel triggered during a scan becomes ACTIVO immediately but is not in pendientes. It is first advanced and issued on the next accepted tick.
- disparo and tick in the same cycle for an INACTIVO channel: the load takes priority, and the channel is not advanced by that tick.

Test Plan:
- Reset mid-EMITE with dir_valida=1 -> all outputs 0 on the same cycle (asynchronous), FSM in REPOSO after release.
- Ch0 inicio=0x100, fin=0x10F, nivel=0 (paso 2), one-shot, ram_listo=1, 10 ticks:
  - dir_ram sequence 0x102, 0x104 ... 0x10E (7 requests).
  - 8th tick: fin_canal[0] pulses, activo[0]=0, no request.
- Same window with modo_loop=1, nivel=3 (paso 5): dir_ram sequence 0x105, 0x10A, 0x10F, 0x100, 0x105.
- Both channels active (ch0 at 0x0, ch1 at 0x285FF0), ram_listo=0 for 3 cycles after tick, then 1:
  - ch0 request held stable for 4 cycles, then ch1 0x285FF2 in the next cycle.
  - Second tick during the scan -> sobrecarga pulse, addresses unchanged.
- detener asserted while ch1 request pending -> dir_valida=0 and activo=0 next cycle; a later disparo[1] restarts ch1 at dir_inicio[1].
- disparo[1] asserted during ch0's scan -> activo[1]=1 immediately, no ch1 request this tick, ch1 at dir_inicio+paso on the next tick.
